// File: rtl/imager_tx.sv
// imager_tx: dtype-tagged image stream back to sensor-style fv/lv/dv timing.
// Headers are stripped, words are buffered, and blanking is regenerated.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module imager_tx #(
    parameter int PIXEL_WIDTH = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_AW     = 4
) (
    input  logic                    clki,
    input  logic                    resetb_clki,
    input  logic                    enable,
    input  logic                    left_justify,
    input  logic [15:0]             hblank,
    input  logic [15:0]             vblank,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]   datai,
    output logic                    fv,
    output logic                    lv,
    output logic                    dvo,
    output logic [PIXEL_WIDTH-1:0]  datao,
    output logic                    overflow,
    output logic                    busy
);

    localparam logic [`DTYPE_WIDTH-1:0] DT_FRAME_START = `DTYPE_WIDTH'(1);
    localparam logic [`DTYPE_WIDTH-1:0] DT_ROW_START   = `DTYPE_WIDTH'(2);
    localparam logic [`DTYPE_WIDTH-1:0] DT_PIXEL       = `DTYPE_WIDTH'(3);
    localparam logic [`DTYPE_WIDTH-1:0] DT_ROW_END     = `DTYPE_WIDTH'(4);
    localparam logic [`DTYPE_WIDTH-1:0] DT_FRAME_END   = `DTYPE_WIDTH'(5);

    localparam logic [FIFO_AW:0]   FULL_C  = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {C_FS, C_RS, C_PX, C_RE, C_FE} code_e;
    typedef enum logic [2:0] {IDLE, FRAME, LINE, HBLANK, VBLANK} state_e;

    logic                     enable_s;
    logic                     gate_open;
    logic                     in_ok;
    code_e                    in_code;
    logic [PIXEL_WIDTH-1:0]   pix_sel;
    logic [PIXEL_WIDTH-1:0]   in_pix;
    logic                     is_fs;
    logic                     is_fe;
    logic                     pass;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [PIXEL_WIDTH+2:0]   mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]       wr_ptr;
    logic [FIFO_AW-1:0]       rd_ptr;
    logic [FIFO_AW:0]         count;
    code_e                    head_code;
    logic [PIXEL_WIDTH-1:0]   head_pix;
    state_e                   state;
    logic [15:0]              cnt;

    // classify the incoming word; anything not a frame/row/pixel marker is dropped
    always_comb begin
        in_ok   = 1'b0;
        in_code = C_FS;
        case (dtypei)
            DT_FRAME_START: begin in_ok = 1'b1; in_code = C_FS; end
            DT_ROW_START:   begin in_ok = 1'b1; in_code = C_RS; end
            DT_PIXEL:       begin in_ok = 1'b1; in_code = C_PX; end
            DT_ROW_END:     begin in_ok = 1'b1; in_code = C_RE; end
            DT_FRAME_END:   begin in_ok = 1'b1; in_code = C_FE; end
            default:        begin in_ok = 1'b0; in_code = C_FS; end
        endcase
    end

    assign pix_sel = left_justify ? datai[DATA_WIDTH-1 -: PIXEL_WIDTH]
                                  : datai[PIXEL_WIDTH-1:0];
    assign in_pix  = (in_code == C_PX) ? pix_sel : '0;
    assign is_fs   = in_ok && (in_code == C_FS);
    assign is_fe   = in_ok && (in_code == C_FE);
    assign pass    = dvi && in_ok && (gate_open || (is_fs && enable_s));

    assign full      = (count == FULL_C);
    assign empty     = (count == '0);
    assign pop       = !empty && (state == IDLE || state == FRAME || state == LINE);
    assign push      = pass && (!full || pop);
    assign head_code = code_e'(mem[rd_ptr][PIXEL_WIDTH +: 3]);
    assign head_pix  = mem[rd_ptr][PIXEL_WIDTH-1:0];

    // sample enable and open/close the frame gate on frame boundaries
    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            enable_s  <= 1'b0;
            gate_open <= 1'b0;
        end else begin
            enable_s <= enable;
            if (pass && is_fs && enable_s)
                gate_open <= 1'b1;
            else if (pass && is_fe && !enable_s)
                gate_open <= 1'b0;
        end
    end

    // FIFO pointers, fill level and sticky overflow
    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (!push && pop)
                count <= count - CNT_ONE;
            if (pass && full && !pop)
                overflow <= 1'b1;
            else if (!enable_s && state == IDLE)
                overflow <= 1'b0;
        end
    end

    // FIFO storage: code plus pixel, no reset needed
    always_ff @(posedge clki) begin
        if (push)
            mem[wr_ptr] <= {in_code, in_pix};
    end

    // timing FSM; blanking counts include the pop cycle that ends the blank
    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            state <= IDLE;
            cnt   <= '0;
            fv    <= 1'b0;
            lv    <= 1'b0;
            dvo   <= 1'b0;
            datao <= '0;
            busy  <= 1'b0;
        end else begin
            busy  <= (state != IDLE) || !empty;
            dvo   <= 1'b0;
            datao <= '0;
            case (state)
                IDLE: begin
                    if (pop && head_code == C_FS) begin
                        fv    <= 1'b1;
                        state <= FRAME;
                    end
                end
                FRAME: begin
                    if (pop) begin
                        case (head_code)
                            C_RS: begin
                                lv    <= 1'b1;
                                state <= LINE;
                            end
                            C_PX: begin
                                lv    <= 1'b1;
                                dvo   <= 1'b1;
                                datao <= head_pix;
                                state <= LINE;
                            end
                            C_FE: begin
                                fv <= 1'b0;
                                if (vblank > 16'd1) begin
                                    cnt   <= vblank - 16'd1;
                                    state <= VBLANK;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                LINE: begin
                    if (pop) begin
                        case (head_code)
                            C_PX: begin
                                dvo   <= 1'b1;
                                datao <= head_pix;
                            end
                            C_RE: begin
                                lv <= 1'b0;
                                if (hblank > 16'd1) begin
                                    cnt   <= hblank - 16'd1;
                                    state <= HBLANK;
                                end else begin
                                    state <= FRAME;
                                end
                            end
                            C_FE: begin
                                lv <= 1'b0;
                                fv <= 1'b0;
                                if (vblank > 16'd1) begin
                                    cnt   <= vblank - 16'd1;
                                    state <= VBLANK;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                HBLANK: begin
                    if (cnt <= 16'd1)
                        state <= FRAME;
                    else
                        cnt <= cnt - 16'd1;
                end
                VBLANK: begin
                    if (cnt <= 16'd1)
                        state <= IDLE;
                    else
                        cnt <= cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imager_tx.sv
// tb_imager_tx: directed and randomized checks of imager_tx timing,
// filtering, gating, overflow, justification and reset behaviour.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module tb_imager_tx;

    localparam int PW = 12;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int TR = 4096;

    localparam logic [3:0] T_FS = 4'd1;
    localparam logic [3:0] T_RS = 4'd2;
    localparam logic [3:0] T_PX = 4'd3;
    localparam logic [3:0] T_RE = 4'd4;
    localparam logic [3:0] T_FE = 4'd5;
    localparam logic [3:0] T_HS = 4'd6;
    localparam logic [3:0] T_HD = 4'd7;
    localparam logic [3:0] T_HE = 4'd8;
    localparam logic [3:0] T_JK = 4'd15;

    typedef logic [PW-1:0] pq_t[$];

    logic                    clki = 1'b0;
    logic                    resetb_clki;
    logic                    enable;
    logic                    left_justify;
    logic [15:0]             hblank;
    logic [15:0]             vblank;
    logic                    dvi;
    logic [`DTYPE_WIDTH-1:0] dtypei;
    logic [DW-1:0]           datai;
    logic                    fv;
    logic                    lv;
    logic                    dvo;
    logic [PW-1:0]           datao;
    logic                    overflow;
    logic                    busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit            fv_tr [TR];
    bit            lv_tr [TR];
    bit            dvo_tr[TR];
    bit            bsy_tr[TR];
    logic [PW-1:0] dat_tr[TR];
    pq_t           got_q;
    pq_t           exp_q;

    imager_tx #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .FIFO_AW(AW)) dut (
        .clki(clki), .resetb_clki(resetb_clki), .enable(enable),
        .left_justify(left_justify), .hblank(hblank), .vblank(vblank),
        .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .fv(fv), .lv(lv), .dvo(dvo), .datao(datao),
        .overflow(overflow), .busy(busy)
    );

    always #5 clki = ~clki;

    always @(posedge clki) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // trace every cycle on the falling edge and check output invariants
    always @(negedge clki) begin
        if (cyc < TR) begin
            fv_tr[cyc]  = fv;
            lv_tr[cyc]  = lv;
            dvo_tr[cyc] = dvo;
            bsy_tr[cyc] = busy;
            dat_tr[cyc] = datao;
        end
        if (dvo === 1'b1) begin
            got_q.push_back(datao);
            check("dvo_in_line", 32'(fv & lv), 32'd1);
        end else begin
            check("datao_idle", 32'(datao), 32'd0);
        end
    end

    function automatic bit sig(input int sel, input int i);
        case (sel)
            0: return fv_tr[i];
            1: return lv_tr[i];
            2: return dvo_tr[i];
            default: return bsy_tr[i];
        endcase
    endfunction

    function automatic int nxt(input int sel, input int from, input bit val);
        for (int i = (from < 0 ? 0 : from); i < cyc && i < TR; i++)
            if (sig(sel, i) == val) return i;
        return -1;
    endfunction

    function automatic int cl(input int i);
        return (i < 0) ? 0 : ((i >= TR) ? TR - 1 : i);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    task automatic put(input logic [3:0] ty, input logic [15:0] d);
        dvi    = 1'b1;
        dtypei = `DTYPE_WIDTH'(ty);
        datai  = d;
        @(posedge clki);
        #1;
        dvi    = 1'b0;
        dtypei = '0;
        datai  = '0;
    endtask

    task automatic cmp_pix(input string tag, input pq_t e);
        check({tag, "_count"}, 32'(got_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(e[i]));
    endtask

    initial begin
        int t0, a, l1r, l1f, l2r, f1f, f2r, l3r, l3f, f2f, n, h0, h1;
        int hr, vr, hmin, vmin, nrows, nframes, r0, r1;
        int lvp, fvp, minlv, minfv, bad, j;
        logic [15:0] d;
        bit lj, skip_rs, skip_re;

        resetb_clki  = 1'b0;
        enable       = 1'b0;
        left_justify = 1'b0;
        hblank       = 16'd4;
        vblank       = 16'd8;
        dvi          = 1'b0;
        dtypei       = '0;
        datai        = '0;
        repeat (3) @(posedge clki);
        #1;
        check("rst_fv", 32'(fv), 32'd0);
        check("rst_lv", 32'(lv), 32'd0);
        check("rst_dvo", 32'(dvo), 32'd0);
        check("rst_datao", 32'(datao), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clki);
        resetb_clki = 1'b1;
        idle(1);
        enable = 1'b1;
        idle(2);

        // basic frame, then a frame whose row markers are trumped
        got_q.delete();
        t0 = cyc;
        put(T_FS, 0); put(T_RS, 0);
        put(T_PX, 1); put(T_PX, 2); put(T_PX, 3); put(T_RE, 0);
        put(T_RS, 0);
        put(T_PX, 4); put(T_PX, 5); put(T_PX, 6); put(T_FE, 0);
        put(T_FS, 0); put(T_PX, 7); put(T_PX, 8); put(T_FE, 0);
        idle(40);
        a = nxt(0, t0, 1);
        check("fs_latency", 32'(a), 32'(t0 + 2));
        l1r = nxt(1, t0, 1);
        l1f = nxt(1, l1r, 0);
        l2r = nxt(1, l1f, 1);
        check("hblank_gap", 32'(l2r - l1f), 32'd4);
        n = 0;
        for (int i = cl(l1r); i < cl(l1f); i++) n += int'(dvo_tr[i]);
        check("row1_dvo", 32'(n), 32'd3);
        f1f = nxt(0, a, 0);
        f2r = nxt(0, f1f, 1);
        check("vblank_gap", 32'(f2r - f1f), 32'd8);
        l3r = nxt(1, f2r, 1);
        check("trump_lv_dvo", 32'(dvo_tr[cl(l3r)]), 32'd1);
        check("trump_lv_data", 32'(dat_tr[cl(l3r)]), 32'd7);
        l3f = nxt(1, l3r, 0);
        f2f = nxt(0, f2r, 0);
        check("trump_fall", 32'(l3f), 32'(f2f));
        cmp_pix("basic_pix", '{12'd1, 12'd2, 12'd3, 12'd4,
                               12'd5, 12'd6, 12'd7, 12'd8});

        // headers between frames leave everything quiet
        h0 = cyc;
        put(T_HS, 16'h1111);
        for (int i = 0; i < 20; i++) put(T_HD, 16'(i));
        put(T_HE, 16'h2222);
        idle(3);
        h1 = cyc;
        bad = 0;
        for (int i = h0; i < h1 && i < TR; i++)
            if (fv_tr[i] || lv_tr[i] || dvo_tr[i] || bsy_tr[i]) bad++;
        check("hdr_quiet", 32'(bad), 32'd0);
        got_q.delete();
        put(T_FS, 0); put(T_RS, 0); put(T_HD, 16'h0055);
        put(T_PX, 9); put(T_JK, 16'h0077); put(T_RE, 0); put(T_FE, 0);
        idle(20);
        cmp_pix("hdr_pix", '{12'd9});

        // pixel justification is chosen per word
        got_q.delete();
        put(T_FS, 0); put(T_RS, 0);
        left_justify = 1'b1; put(T_PX, 16'hABC0);
        left_justify = 1'b0; put(T_PX, 16'h0ABC);
        left_justify = 1'b1; put(T_PX, 16'h1234);
        left_justify = 1'b0; put(T_PX, 16'h1234);
        put(T_RE, 0); put(T_FE, 0);
        idle(20);
        cmp_pix("just", '{12'hABC, 12'hABC, 12'h123, 12'h234});

        // dropping enable mid-row lets the frame finish, then blocks
        got_q.delete();
        put(T_FS, 0); put(T_RS, 0); put(T_PX, 30); put(T_PX, 31);
        enable = 1'b0;
        put(T_PX, 32); put(T_RE, 0); put(T_FE, 0);
        idle(30);
        t0 = cyc;
        put(T_FS, 0); put(T_RS, 0); put(T_PX, 33); put(T_RE, 0); put(T_FE, 0);
        idle(20);
        check("en_off_no_fv", 32'(nxt(0, t0, 1)), 32'(-1));
        check("en_off_busy", 32'(busy), 32'd0);
        cmp_pix("en_pix", '{12'd30, 12'd31, 12'd32});

        // overflow while the FSM sits in a long horizontal blank
        enable = 1'b1;
        hblank = 16'd100;
        idle(2);
        got_q.delete();
        put(T_FS, 0); put(T_RS, 0); put(T_PX, 20); put(T_RE, 0);
        put(T_RS, 0);
        for (int i = 21; i <= 28; i++) put(T_PX, 16'(i));
        check("ovf_set", 32'(overflow), 32'd1);
        idle(110);
        cmp_pix("ovf_pix", '{12'd20, 12'd21, 12'd22, 12'd23});
        check("ovf_lv_held", 32'(lv), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        hblank = 16'd4;
        enable = 1'b0;
        idle(2);
        put(T_RE, 0); put(T_FE, 0);
        check("ovf_not_idle", 32'(overflow), 32'd1);
        idle(30);
        check("ovf_clear", 32'(overflow), 32'd0);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_fv", 32'(fv), 32'd0);

        // asynchronous reset in the middle of a line
        enable = 1'b1;
        idle(2);
        put(T_FS, 0); put(T_RS, 0); put(T_PX, 40);
        for (int k = 0; k < 50 && lv !== 1'b1; k++) idle(1);
        check("rst_mid_lv", 32'(lv), 32'd1);
        #2;
        resetb_clki = 1'b0;
        #1;
        check("rst_async_fv", 32'(fv), 32'd0);
        check("rst_async_lv", 32'(lv), 32'd0);
        check("rst_async_dvo", 32'(dvo), 32'd0);
        @(negedge clki);
        resetb_clki = 1'b1;
        idle(1);
        check("rst_rel_busy", 32'(busy), 32'd0);
        got_q.delete();
        t0 = cyc;
        put(T_RS, 0); put(T_PX, 41); put(T_RE, 0); put(T_FE, 0);
        idle(10);
        check("rst_no_fs_fv", 32'(nxt(0, t0, 1)), 32'(-1));
        check("rst_no_fs_pix", 32'(got_q.size()), 32'd0);
        t0 = cyc;
        put(T_FS, 0); put(T_RS, 0); put(T_PX, 42); put(T_RE, 0); put(T_FE, 0);
        idle(20);
        check("rst_fresh_fv", 32'(nxt(0, t0, 1) > 0), 32'd1);
        cmp_pix("rst_pix", '{12'd42});

        // randomized frames against a transaction-level expectation
        hr = $urandom_range(0, 2);
        vr = $urandom_range(0, 2);
        hblank = 16'(hr);
        vblank = 16'(vr);
        hmin = (hr < 1) ? 1 : hr;
        vmin = (vr < 1) ? 1 : vr;
        idle(4);
        got_q.delete();
        exp_q.delete();
        nrows = 0;
        nframes = $urandom_range(4, 6);
        r0 = cyc;
        for (int f = 0; f < nframes; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                put(T_HS, 0);
                repeat ($urandom_range(1, 4)) put(T_HD, 16'($urandom));
                put(T_HE, 0);
            end
            put(T_FS, 0);
            for (int r = 0, nr = $urandom_range(1, 3); r < nr; r++) begin
                nrows++;
                skip_rs = ($urandom_range(0, 3) == 0);
                skip_re = (r == nr - 1) && ($urandom_range(0, 1) == 1);
                if (!skip_rs) put(T_RS, 0);
                for (int p = 0, np = $urandom_range(1, 6); p < np; p++) begin
                    if ($urandom_range(0, 3) == 0) put(T_JK, 16'($urandom));
                    if ($urandom_range(0, 3) == 0) put(T_HD, 16'($urandom));
                    if ($urandom_range(0, 2) == 0) idle(1);
                    d  = 16'($urandom);
                    lj = 1'($urandom_range(0, 1));
                    left_justify = lj;
                    exp_q.push_back(lj ? d[15:4] : d[11:0]);
                    put(T_PX, d);
                end
                if (!skip_re) put(T_RE, 0);
                idle(3);
            end
            put(T_FE, 0);
            idle(4);
        end
        idle(20);
        r1 = cyc;
        cmp_pix("rand_pix", exp_q);
        lvp = 0;
        fvp = 0;
        minlv = 1000000;
        minfv = 1000000;
        for (int i = r0 + 1; i < r1 && i < TR; i++) begin
            if (lv_tr[i] && !lv_tr[i-1]) lvp++;
            if (fv_tr[i] && !fv_tr[i-1]) fvp++;
            if (!lv_tr[i] && lv_tr[i-1] && fv_tr[i]) begin
                j = nxt(1, i, 1);
                if (j > 0 && j - i < minlv) minlv = j - i;
            end
            if (!fv_tr[i] && fv_tr[i-1]) begin
                j = nxt(0, i, 1);
                if (j > 0 && j < r1 && j - i < minfv) minfv = j - i;
            end
        end
        check("rand_lv_pulses", 32'(lvp), 32'(nrows));
        check("rand_fv_pulses", 32'(fvp), 32'(nframes));
        check("rand_hblank_min", 32'(minlv >= hmin), 32'd1);
        check("rand_vblank_min", 32'(minfv >= vmin), 32'd1);
        check("rand_no_ovf", 32'(overflow), 32'd0);
        check("rand_end_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
